// File: rtl/vc_pkg.sv
// vc_pkg: shared widths and destination codes for the VC destination router
package vc_pkg;
    localparam int BW_DEF = 6;
    localparam int DEST_BIT_DEF = 4;
    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;
    localparam int CNT_W = 8;
    localparam int DROP_W = 4;
endpackage

// File: rtl/vc_skid_reg.sv
// vc_skid_reg: one-word skid register in front of a destination FIFO, older word wins
module vc_skid_reg import vc_pkg::*; #(
    parameter int BW = BW_DEF
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          inc,
    input  logic          full,
    input  logic [BW-1:0] in_data,
    output logic          push,
    output logic [BW-1:0] data,
    output logic          hold,
    output logic          drop
);
    logic          hold_v;
    logic [BW-1:0] hold_q;
    assign push = !full & (hold_v | inc);
    assign data = hold_v ? hold_q : in_data;
    assign hold = hold_v;
    assign drop = full & inc & hold_v;
    // load on refill (held word leaves, incoming stays) or on first capture while full
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            hold_v <= 1'b0;
            hold_q <= '0;
        end else begin
            hold_v <= hold_v ? (full | inc) : (full & inc);
            if (inc & (hold_v ^ full))
                hold_q <= in_data;
        end
    end
endmodule

// File: rtl/vc_dest_router.sv
// vc_dest_router: aligns VC0/VC1 pops with FIFO read data and routes words to D0/D1 via skid registers
// Optional VC_ROUTE_CNT_EN adds per-destination push counters and a saturating drop counter.
module vc_dest_router import vc_pkg::*; #(
    parameter int BW = BW_DEF,
    parameter int DEST_BIT = DEST_BIT_DEF
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          VC0_rd,
    input  logic          VC1_rd,
    input  logic          vc0_delay,
    input  logic [BW-1:0] VC0_data,
    input  logic [BW-1:0] VC1_data,
    input  logic          D0_full,
    input  logic          D1_full,
    output logic          D0_push,
    output logic [BW-1:0] D0_data,
    output logic          D1_push,
    output logic [BW-1:0] D1_data,
    output logic          D0_hold,
    output logic          D1_hold,
    output logic          route_err
`ifdef VC_ROUTE_CNT_EN
    ,
    output logic [CNT_W-1:0]  D0_cnt,
    output logic [CNT_W-1:0]  D1_cnt,
    output logic [DROP_W-1:0] drop_cnt
`endif
);
    logic          pend_q, sel_q, in_v_q;
    logic [BW-1:0] in_q;
    logic          inc0, inc1, drop0, drop1;
    // a simultaneous pop of both VCs is illegal; VC0 wins and the event is flagged
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            pend_q    <= 1'b0;
            sel_q     <= 1'b0;
            in_v_q    <= 1'b0;
            in_q      <= '0;
            route_err <= 1'b0;
        end else begin
            pend_q    <= VC0_rd | VC1_rd;
            sel_q     <= vc0_delay & VC1_rd & !VC0_rd;
            in_v_q    <= pend_q;
            in_q      <= sel_q ? VC1_data : VC0_data;
            route_err <= route_err | (VC0_rd & VC1_rd) | drop0 | drop1;
        end
    end
    assign inc0 = in_v_q & (in_q[DEST_BIT] == DEST_D0);
    assign inc1 = in_v_q & (in_q[DEST_BIT] == DEST_D1);
    vc_skid_reg #(.BW(BW)) u_skid0 (
        .clk(clk), .reset_L(reset_L), .inc(inc0), .full(D0_full), .in_data(in_q),
        .push(D0_push), .data(D0_data), .hold(D0_hold), .drop(drop0)
    );
    vc_skid_reg #(.BW(BW)) u_skid1 (
        .clk(clk), .reset_L(reset_L), .inc(inc1), .full(D1_full), .in_data(in_q),
        .push(D1_push), .data(D1_data), .hold(D1_hold), .drop(drop1)
    );
`ifdef VC_ROUTE_CNT_EN
    logic [DROP_W:0] drop_sum;
    assign drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(drop0) + (DROP_W+1)'(drop1);
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            D0_cnt   <= '0;
            D1_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            D0_cnt   <= D0_cnt + CNT_W'(D0_push);
            D1_cnt   <= D1_cnt + CNT_W'(D1_push);
            drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
    end
`endif
endmodule

// File: tb/tb_vc_dest_router.sv
// tb_vc_dest_router: table-driven routing vectors plus skid/overflow/reset sequences, scoreboarded per destination
module tb_vc_dest_router;
    typedef struct {
        logic       vc1;
        logic       dly;
        logic [5:0] data;
        logic       d1;
    } vec_t;
    typedef struct {
        logic [5:0] data;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_L, VC0_rd, VC1_rd, vc0_delay, D0_full, D1_full;
    logic [5:0] VC0_data, VC1_data, D0_data, D1_data;
    logic       D0_push, D1_push, D0_hold, D1_hold, route_err;
`ifdef VC_ROUTE_CNT_EN
    logic [7:0] D0_cnt, D1_cnt;
    logic [3:0] drop_cnt;
`endif

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n0 = 0;
    int   n1 = 0;
    logic mon_en = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    localparam int NV = 10;
    vec_t tbl[NV];

    vc_dest_router dut (
        .clk(clk), .reset_L(reset_L), .VC0_rd(VC0_rd), .VC1_rd(VC1_rd), .vc0_delay(vc0_delay),
        .VC0_data(VC0_data), .VC1_data(VC1_data), .D0_full(D0_full), .D1_full(D1_full),
        .D0_push(D0_push), .D0_data(D0_data), .D1_push(D1_push), .D1_data(D1_data),
        .D0_hold(D0_hold), .D1_hold(D1_hold), .route_err(route_err)
`ifdef VC_ROUTE_CNT_EN
        , .D0_cnt(D0_cnt), .D1_cnt(D1_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // every cycle each destination must push exactly what the scoreboard says is due now
    always @(negedge clk) begin
        if (mon_en) begin
            if (q0.size() > 0 && q0[0].due == cyc) begin
                e0 = q0.pop_front();
                check("d0_push", D0_push, 1);
                check("d0_data", D0_data, e0.data);
                n0++;
            end else
                check("d0_idle", D0_push, 0);
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e1 = q1.pop_front();
                check("d1_push", D1_push, 1);
                check("d1_data", D1_data, e1.data);
                n1++;
            end else
                check("d1_idle", D1_push, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b0, 1'b0, 6'b000101, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 6'b010011, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 6'b011100, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 6'b101010, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 6'b000000, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 6'b111111, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 6'b000000, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 6'b111111, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 6'b100101, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 6'b010000, 1'b1};
        reset_L = 0; VC0_rd = 0; VC1_rd = 0; vc0_delay = 0;
        VC0_data = 0; VC1_data = 0; D0_full = 0; D1_full = 0;
        tick();
        mon_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_hold0", D0_hold, 0);
        check("rst_hold1", D1_hold, 0);
        check("rst_err", route_err, 0);
        check("rst_d0_data", D0_data, 0);
        check("rst_d1_data", D1_data, 0);
        tick();
        reset_L = 1;

        // back-to-back pops across both VCs and destinations, data one cycle after the pop
        for (int i = 0; i <= NV; i++) begin
            tick();
            VC0_rd = 0; VC1_rd = 0; vc0_delay = 0;
            if (i < NV) begin
                VC0_rd = !tbl[i].vc1;
                VC1_rd = tbl[i].vc1;
                vc0_delay = tbl[i].dly;
                if (tbl[i].d1) q1.push_back('{tbl[i].data, cyc + 2});
                else q0.push_back('{tbl[i].data, cyc + 2});
            end
            if (i > 0) begin
                VC0_data = tbl[i-1].vc1 ? ~tbl[i-1].data : tbl[i-1].data;
                VC1_data = tbl[i-1].vc1 ? tbl[i-1].data : ~tbl[i-1].data;
            end
        end
        tick(); VC0_data = 0; VC1_data = 0;
        repeat (3) tick();

        // skid: word parks while D0 is full, drains when it frees up
        D0_full = 1; VC0_rd = 1;
        tick(); VC0_rd = 0; VC0_data = 6'b000111;
        tick(); VC0_data = 0;
        @(negedge clk); check("skid_hold_pre", D0_hold, 0);
        tick();
        @(negedge clk); check("skid_hold", D0_hold, 1);
        tick(); D0_full = 0; q0.push_back('{6'b000111, cyc});
        tick();
        @(negedge clk); check("skid_empty", D0_hold, 0);
        repeat (2) tick();

        // priority + refill: held A goes first, incoming B takes its place
        D0_full = 1; VC0_rd = 1;
        tick(); VC0_data = 6'b001010;
        tick(); VC0_rd = 0; VC0_data = 6'b100011;
        tick(); D0_full = 0; VC0_data = 0;
        q0.push_back('{6'b001010, cyc});
        q0.push_back('{6'b100011, cyc + 1});
        @(negedge clk); check("refill_hold_a", D0_hold, 1);
        tick();
        @(negedge clk); check("refill_hold_b", D0_hold, 1);
        tick();
        @(negedge clk); check("refill_empty", D0_hold, 0);
        repeat (2) tick();

        // overflow: second D0 word dropped; later D0 skid and D1 incoming push together
        D0_full = 1; VC0_rd = 1;
        tick(); VC0_data = 6'b000011;
        tick(); VC0_rd = 0; VC0_data = 6'b101100;
        tick(); VC0_rd = 1; VC0_data = 0;
        @(negedge clk); check("ovf_err_pre", route_err, 0);
        tick(); VC0_rd = 0; VC0_data = 6'b110110;
        @(negedge clk);
        check("ovf_err", route_err, 1);
        check("ovf_hold", D0_hold, 1);
`ifdef VC_ROUTE_CNT_EN
        check("ovf_drop_cnt", drop_cnt, 1);
`endif
        tick(); D0_full = 0; VC0_data = 0;
        q0.push_back('{6'b000011, cyc});
        q1.push_back('{6'b110110, cyc});
        tick();
        @(negedge clk);
        check("ovf_sticky", route_err, 1);
        check("ovf_hold_empty", D0_hold, 0);
        repeat (2) tick();

        // reset while both skids are full and a word sits in the capture stage
        D0_full = 1; D1_full = 1; VC0_rd = 1;
        tick(); VC0_data = 6'b001001;
        tick(); VC0_data = 6'b011000;
        tick(); VC0_data = 6'b000110;
        tick(); VC0_data = 6'b010101; reset_L = 0;
        @(negedge clk);
        check("mid_hold0", D0_hold, 1);
        check("mid_hold1", D1_hold, 1);
        check("mid_err", route_err, 1);
        tick(); reset_L = 1; VC0_rd = 0; D0_full = 0; D1_full = 0; n0 = 0; n1 = 0;
        @(negedge clk);
        check("post_rst_hold0", D0_hold, 0);
        check("post_rst_hold1", D1_hold, 0);
        check("post_rst_err", route_err, 0);
        check("post_rst_d0_data", D0_data, 0);
        check("post_rst_d1_data", D1_data, 0);
        tick(); VC0_data = 0;
        repeat (4) tick();

        // illegal dual pop: VC0 wins and the error latches
        VC0_rd = 1; VC1_rd = 1; vc0_delay = 1;
        tick(); VC0_rd = 0; VC1_rd = 0; vc0_delay = 0;
        VC0_data = 6'b010110; VC1_data = 6'b000001;
        q1.push_back('{6'b010110, cyc + 1});
        @(negedge clk); check("dual_err", route_err, 1);
        tick(); VC0_data = 0; VC1_data = 0;
        repeat (3) tick();
`ifdef VC_ROUTE_CNT_EN
        check("d0_cnt", D0_cnt, n0[7:0]);
        check("d1_cnt", D1_cnt, n1[7:0]);
        check("drop_cnt_rst", drop_cnt, 0);
`endif
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
